// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_D  = 1'b1
    } arb_src_t;

    // Width able to hold 0..max_starve inclusive.
    function automatic int starve_width(input int max_starve);
        return (max_starve < 1) ? 1 : $clog2(max_starve + 1);
    endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable down-counter with a zero flag; times the memory access window.
module arb_wait_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one fixed-latency memory port.
// Optional per-port stall counters are enabled with the ARB_STALL_CNT_EN macro.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int MAX_STARVE = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
`ifdef ARB_STALL_CNT_EN
    output logic [31:0]   if_stall_cnt,
    output logic [31:0]   d_stall_cnt,
`endif
    output logic          grant_src
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int SW = starve_width(MAX_STARVE);
    localparam logic [CW-1:0] LOAD_VAL   = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

    arb_state_t    state;
    arb_state_t    next_state;
    arb_src_t      src_l;
    logic          we_l;
    logic [AW-1:0] addr_l;
    logic [DW-1:0] wdata_l;
    logic [SW-1:0] starve;
    logic [CW-1:0] wait_count;
    logic          wait_zero;
    logic          any_req;
    logic          fetch_wins;
    logic          accept;
    logic          sample;

    assign any_req    = if_req | d_req;
    assign fetch_wins = if_req && (!d_req || (starve == STARVE_MAX));
    assign accept     = (state == IDLE) && any_req;
    assign sample     = (state == ACCESS) && wait_zero;

    arb_wait_counter #(.W(CW)) u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (LOAD_VAL),
        .dec      (state == ACCESS),
        .count    (wait_count),
        .zero     (wait_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ACCESS;
            ACCESS:  if (wait_zero) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_l   <= SRC_IF;
            we_l    <= 1'b0;
            addr_l  <= '0;
            wdata_l <= '0;
        end else if (accept) begin
            src_l   <= fetch_wins ? SRC_IF : SRC_D;
            we_l    <= !fetch_wins && d_we;
            addr_l  <= fetch_wins ? if_addr : d_addr;
            wdata_l <= fetch_wins ? '0 : d_wdata;
        end
    end

    // Starve count only grows when fetch actually lost a contested grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (accept) begin
            if (fetch_wins) begin
                starve <= '0;
            end else if (if_req && (starve != STARVE_MAX)) begin
                starve <= starve + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if (sample && !we_l) begin
            if (src_l == SRC_IF) begin
                if_rdata <= mem_rdata;
            end else begin
                d_rdata <= mem_rdata;
            end
        end
    end

    assign mem_read  = (state == ACCESS) && !we_l;
    assign mem_write = (state == ACCESS) && we_l;
    assign mem_addr  = (state == ACCESS) ? addr_l : '0;
    assign mem_wdata = (state == ACCESS) ? wdata_l : '0;
    assign if_ready  = (state == RESP) && (src_l == SRC_IF);
    assign d_ready   = (state == RESP) && (src_l == SRC_D);
    assign busy      = (state != IDLE);
    assign grant_src = src_l;

`ifdef ARB_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_stall_cnt <= '0;
            d_stall_cnt  <= '0;
        end else begin
            if (if_req && !if_ready) if_stall_cnt <= if_stall_cnt + 32'd1;
            if (d_req && !d_ready) d_stall_cnt <= d_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
